// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchronizer, polarity normalization, debounce,
// press/release/long-press strobes, toggle level and wrapping press counter.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned CNT_W           = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       toggle_state,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_LONG} state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] r_hold_cnt;
  state_t           r_state;

  logic w_raw_p;
  logic w_db_done;
  logic w_rise;
  logic w_fall;

  assign w_raw_p   = r_sync2 ^ ACTIVE_LOW;
  assign w_db_done = (w_raw_p != btn_level) && (r_db_cnt == DB_LAST);
  assign w_rise    = w_db_done & w_raw_p;
  assign w_fall    = w_db_done & ~w_raw_p;

  // Synchronizer resets to the released pin value so a held button cannot fake an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_cnt      <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= w_rise;
      release_pulse <= w_fall;
      if (w_raw_p == btn_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        btn_level <= w_raw_p;
        r_db_cnt  <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_state <= 1'b0;
      press_count  <= 8'd0;
    end else if (w_rise) begin
      toggle_state <= ~toggle_state;
      press_count  <= press_count + 8'd1;
    end
  end

  // Long-press FSM; a release on the firing edge takes priority over long_pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_hold_cnt <= '0;
          if (w_rise) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (w_fall) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == LONG_CNT) begin
            r_state    <= S_LONG;
            long_pulse <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        S_LONG: begin
          if (w_fall) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected events queued by stimulus,
// popped by per-DUT monitors whenever any strobe is seen.
module tb_button_conditioner;

  localparam int unsigned DB   = 4;
  localparam int unsigned LNG  = 20;
  localparam int unsigned LAT  = 2 + DB;

  localparam logic [2:0] K_PRESS = 3'b001;
  localparam logic [2:0] K_REL   = 3'b010;
  localparam logic [2:0] K_LONG  = 3'b100;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  kind;
    logic        lvl;
    logic        tog;
    logic [7:0]  cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic pin_a = 1'b1;
  logic rst_b = 1'b1;
  logic pin_b = 1'b0;

  logic       a_lvl, a_press, a_rel, a_long, a_tog;
  logic [7:0] a_cnt;
  logic       b_lvl, b_press, b_rel, b_long, b_tog;
  logic [7:0] b_cnt;

  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  ev_t         qa[$];
  ev_t         qb[$];
  int          a_cnt_m = 0;
  logic        a_tog_m = 1'b0;

  button_conditioner #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LNG), .ACTIVE_LOW(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(rst_a), .btn_raw(pin_a), .btn_level(a_lvl), .press_pulse(a_press),
    .release_pulse(a_rel), .long_pulse(a_long), .toggle_state(a_tog), .press_count(a_cnt));

  button_conditioner #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LNG), .ACTIVE_LOW(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(rst_b), .btn_raw(pin_b), .btn_level(b_lvl), .press_pulse(b_press),
    .release_pulse(b_rel), .long_pulse(b_long), .toggle_state(b_tog), .press_count(b_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input bit sel, input int unsigned c, input logic [2:0] k, input logic l,
                      input logic t, input logic [7:0] n);
    ev_t e;
    e.cyc = c; e.kind = k; e.lvl = l; e.tog = t; e.cnt = n;
    if (sel) qb.push_back(e); else qa.push_back(e);
  endtask

  // Press DUT A for low_n cycles, then release for high_n cycles.
  task automatic do_press(input int low_n, input int high_n);
    int unsigned c;
    c = cyc;
    pin_a = 1'b0;
    a_cnt_m = (a_cnt_m + 1) % 256;
    a_tog_m = ~a_tog_m;
    push(1'b0, c + LAT, K_PRESS, 1'b1, a_tog_m, 8'(a_cnt_m));
    if (low_n > int'(LNG)) push(1'b0, c + LAT + LNG, K_LONG, 1'b1, a_tog_m, 8'(a_cnt_m));
    push(1'b0, c + low_n + LAT, K_REL, 1'b0, a_tog_m, 8'(a_cnt_m));
    tick(low_n);
    pin_a = 1'b1;
    tick(high_n);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_lvl"}, 32'(a_lvl), 0);
    check({tag, "_press"}, 32'(a_press), 0);
    check({tag, "_rel"}, 32'(a_rel), 0);
    check({tag, "_long"}, 32'(a_long), 0);
    check({tag, "_tog"}, 32'(a_tog), 0);
    check({tag, "_cnt"}, 32'(a_cnt), 0);
  endtask

  always @(negedge clk) begin
    if (a_press | a_rel | a_long) begin
      if (qa.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL A_unexpected_event: got press=%0b rel=%0b long=%0b required none (cycle %0d)",
                 a_press, a_rel, a_long, cyc);
      end else begin
        ev_t e;
        e = qa.pop_front();
        check("A_ev_cycle", cyc, e.cyc);
        check("A_ev_kind", 32'({a_long, a_rel, a_press}), 32'(e.kind));
        check("A_ev_level", 32'(a_lvl), 32'(e.lvl));
        check("A_ev_toggle", 32'(a_tog), 32'(e.tog));
        check("A_ev_count", 32'(a_cnt), 32'(e.cnt));
      end
    end
  end

  always @(negedge clk) begin
    if (b_press | b_rel | b_long) begin
      if (qb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL B_unexpected_event: got press=%0b rel=%0b long=%0b required none (cycle %0d)",
                 b_press, b_rel, b_long, cyc);
      end else begin
        ev_t e;
        e = qb.pop_front();
        check("B_ev_cycle", cyc, e.cyc);
        check("B_ev_kind", 32'({b_long, b_rel, b_press}), 32'(e.kind));
        check("B_ev_level", 32'(b_lvl), 32'(e.lvl));
        check("B_ev_toggle", 32'(b_tog), 32'(e.tog));
        check("B_ev_count", 32'(b_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    int el;
    int unsigned d;

    tick(3);
    check_zero_a("A_reset");
    rst_a = 1'b0;
    tick(3);

    // Clean press held 30 cycles past btn_level, then release.
    do_press(LAT + 30, 10);

    // Glitches of 1, 2, 3 low cycles with 2-cycle high gaps.
    pin_a = 1'b0;
    el = 0;
    for (int w = 1; w <= 3; w++) begin
      tick(w - el);
      pin_a = 1'b1;
      tick(2);
      if (w < 3) pin_a = 1'b0;
      tick(1);
      el = (w < 3) ? 1 : 0;
      check("A_glitch_dbcnt", 32'(dut_a.r_db_cnt), 0);
      check("A_glitch_level", 32'(a_lvl), 0);
    end
    tick(10);

    // Short press, then long-press boundary at exactly LONG and LONG+1.
    do_press(10, 10);
    check("A_short_count", 32'(a_cnt), 2);
    check("A_short_toggle", 32'(a_tog), 0);
    do_press(LNG, 10);
    do_press(LNG + 1, 10);

    for (int k = a_cnt_m; k < 256; k++) do_press(8, 8);
    check("A_wrap_count", 32'(a_cnt), 0);
    check("A_wrap_toggle", 32'(a_tog), 0);

    // Reset while in LONG with pin still held.
    d = cyc;
    pin_a = 1'b0;
    a_cnt_m = a_cnt_m + 1;
    a_tog_m = ~a_tog_m;
    push(1'b0, d + LAT, K_PRESS, 1'b1, a_tog_m, 8'(a_cnt_m));
    push(1'b0, d + LAT + LNG, K_LONG, 1'b1, a_tog_m, 8'(a_cnt_m));
    tick(30);
    rst_a = 1'b1;
    tick(1);
    check_zero_a("A_midreset");
    check("A_midreset_hold", 32'(dut_a.r_hold_cnt), 0);
    tick(1);
    rst_a = 1'b0;
    d = cyc;
    a_cnt_m = 1;
    a_tog_m = 1'b1;
    push(1'b0, d + LAT, K_PRESS, 1'b1, 1'b1, 8'd1);
    push(1'b0, d + LAT + LNG, K_LONG, 1'b1, 1'b1, 8'd1);
    tick(30);
    pin_a = 1'b1;
    push(1'b0, cyc + LAT, K_REL, 1'b0, 1'b1, 8'd1);
    tick(10);

    // Active-high pin build.
    check("B_reset_level", 32'(b_lvl), 0);
    check("B_reset_count", 32'(b_cnt), 0);
    rst_b = 1'b0;
    tick(3);
    d = cyc;
    pin_b = 1'b1;
    push(1'b1, d + LAT, K_PRESS, 1'b1, 1'b1, 8'd1);
    tick(12);
    pin_b = 1'b0;
    push(1'b1, cyc + LAT, K_REL, 1'b0, 1'b1, 8'd1);
    tick(10);
    pin_b = 1'b1;
    rst_b = 1'b1;
    tick(5);
    check("B_heldreset_level", 32'(b_lvl), 0);
    check("B_heldreset_toggle", 32'(b_tog), 0);
    rst_b = 1'b0;
    d = cyc;
    push(1'b1, d + LAT, K_PRESS, 1'b1, 1'b1, 8'd1);
    tick(10);
    pin_b = 1'b0;
    push(1'b1, cyc + LAT, K_REL, 1'b0, 1'b1, 8'd1);
    tick(12);

    check("A_pending_events", qa.size(), 0);
    check("B_pending_events", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
